// File: rtl/banco_reg_wb_arbiter.sv
// Write-back arbiter for the single register-file write port: round-robin among
// NREQ sources with bounded burst locking; registered outputs feed the file directly.
module banco_reg_wb_arbiter #(
    parameter int NREQ     = 3,
    parameter int LOCK_MAX = 4
) (
    input  logic                 iCLK,
    input  logic                 iRST_N,
    input  logic [NREQ-1:0]      iReq,
    input  logic [NREQ-1:0]      iLock,
    input  logic [5*NREQ-1:0]    iAddr,
    input  logic [32*NREQ-1:0]   iData,
    output logic [NREQ-1:0]      oGnt,
    output logic                 oRegWrite,
    output logic [4:0]           oWriteRegister,
    output logic [31:0]          oWriteData,
    output logic [15:0]          oStallCnt
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int LW = $clog2(LOCK_MAX + 1);
    localparam logic [LW-1:0] LOCK_MAX_C = LW'(LOCK_MAX);

    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            we_q, we_d;
    logic [4:0]      wr_q, wr_d;
    logic [31:0]     wd_q, wd_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [LW-1:0]   lcnt_q, lcnt_d;
    logic [15:0]     stall_q, stall_d;

    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] rr_set;
    logic [NREQ-1:0] win_oh;
    logic            hold;
    int              hold_idx;
    logic            cont;
    logic            win_vld;
    int              win_idx;
    int              rr_idx;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        elig     = iReq & ~(gnt_q & ~iLock);
        rr_set   = elig & ~gnt_q;
        hold     = 1'b0;
        hold_idx = 0;
        win_vld  = 1'b0;
        win_idx  = 0;
        rr_idx   = 0;
        win_oh   = '0;
        lcnt_d   = '0;
        we_d     = 1'b0;
        wr_d     = wr_q;
        wd_d     = wd_q;
        ptr_d    = ptr_q;
        stall_d  = stall_q;

        for (int k = 0; k < NREQ; k++) begin
            if (gnt_q[k] && iLock[k] && iReq[k]) begin
                hold     = 1'b1;
                hold_idx = k;
            end
        end

        // A locked holder keeps the port until the bound is hit and someone else is waiting.
        cont = hold && ((lcnt_q < LOCK_MAX_C) || (rr_set == '0));

        if (cont) begin
            win_vld = 1'b1;
            win_idx = hold_idx;
            lcnt_d  = (lcnt_q == LOCK_MAX_C) ? lcnt_q : lcnt_q + 1'b1;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                rr_idx = int'(ptr_q) + i;
                if (rr_idx >= NREQ) rr_idx = rr_idx - NREQ;
                if (!win_vld && rr_set[rr_idx]) begin
                    win_vld = 1'b1;
                    win_idx = rr_idx;
                end
            end
        end

        if (win_vld) begin
            win_oh[win_idx] = 1'b1;
            wr_d  = iAddr[win_idx*5 +: 5];
            wd_d  = iData[win_idx*32 +: 32];
            we_d  = (iAddr[win_idx*5 +: 5] != 5'd0);
            ptr_d = (win_idx == NREQ - 1) ? '0 : PW'(win_idx + 1);
        end

        gnt_d = win_oh;

        if (((elig & ~win_oh) != '0) && (stall_q != 16'hFFFF))
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge iCLK) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!iRST_N) begin
            gnt_q   <= '0;
            we_q    <= 1'b0;
            wr_q    <= '0;
            wd_q    <= '0;
            ptr_q   <= '0;
            lcnt_q  <= '0;
            stall_q <= '0;
        end else begin
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            wr_q    <= wr_d;
            wd_q    <= wd_d;
            ptr_q   <= ptr_d;
            lcnt_q  <= lcnt_d;
            stall_q <= stall_d;
        end
    end

    assign oGnt           = gnt_q;
    assign oRegWrite      = we_q;
    assign oWriteRegister = wr_q;
    assign oWriteData     = wd_q;
    assign oStallCnt      = stall_q;

endmodule
